alu_exec_seq: RTL and testbench
===============================

ALU_EXEC_SEQ -- requirements
Module: alu_exec_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath width in bits (legal 8..64).
REQ-002 SHALL have parameter FUNC_W, default 4, function-field width (legal 4..6).
REQ-003 SHALL have port clk  input  1  sole clock, all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port in_valid  input  1  request present.
REQ-006 SHALL have port in_ready  output  1  block can accept a request.
REQ-007 SHALL have port sig_ALUop  input  2  main-decoder ALU opcode.
REQ-008 SHALL have port func  input  FUNC_W  R-type function field.
REQ-009 SHALL have ports a, b  input  WIDTH  operands.
REQ-010 SHALL have port out_valid  output  1  result present.
REQ-011 SHALL have port out_ready  input  1  consumer accepts result.
REQ-012 SHALL have port result  output  WIDTH  operation result.
REQ-013 SHALL have port zero  output  1  result equals 0.
REQ-014 SHALL have port ovf  output  1  signed overflow (ADD/SUB only, else 0).
REQ-015 SHALL have port alu_control  output  3  registered decoded operation of the captured request.

Function
REQ-016 Decode SHALL be: ALUop 11->ADD(000); 10->SUB(001); 01->AND(010); 00 with func value 0->OR(011), 1->ADD, 2->SUB, 3->AND, 4->SLT(100), 5->MUL(101); any other combination->ADD.
REQ-017 With ALUop 00, func bits above bit 3 non-zero SHALL decode to ADD.
REQ-018 FSM states SHALL be IDLE, MUL, HOLD; in_ready=1 only in IDLE.
REQ-019 Accept SHALL occur when in_valid&&in_ready; a, b, decoded op are captured; alu_control updates to decoded op that edge.
REQ-020 IDLE, accepted non-MUL op: result, zero, ovf registered on the accept edge; next state HOLD (out_valid high the cycle after accept).
REQ-021 IDLE, accepted MUL: next state MUL; counter loaded with WIDTH; accumulator cleared.
REQ-022 MUL state SHALL perform one shift-add step per cycle (LSB of multiplier shifts out; multiplicand shifts left); after WIDTH steps, result = low WIDTH bits of a*b (unsigned), zero updated, ovf=0, go HOLD; out_valid rises WIDTH+1 cycles after accept.
REQ-023 ADD/SUB SHALL be modulo 2^WIDTH; ovf=1 when operand signs (b inverted for SUB) agree and result sign differs.
REQ-024 SLT SHALL be signed: result=1 if $signed(a)<$signed(b) else 0.
REQ-025 HOLD: out_valid=1; result, zero, ovf, alu_control stable; leave to IDLE on edge where out_ready=1.
REQ-026 in_valid while busy SHALL be ignored (no capture, no state change); requester must hold it.
REQ-027 out_ready while not in HOLD SHALL have no effect.
REQ-028 Handshake SHALL be non-overlapping: a new request is accepted at earliest the cycle after the HOLD->IDLE edge.
REQ-029 Operand inputs SHALL not be sampled after accept; changes during MUL/HOLD do not affect result.

Reset
REQ-030 rst=1 at a rising edge SHALL force IDLE, in_ready=1, out_valid=0, result=0, zero=1, ovf=0, alu_control=000, counter=0, accumulator=0.
REQ-031 Reset SHALL override any handshake that same edge and abort an in-progress MUL; no result is delivered.

Verification
REQ-032 ALUop=00, func=0, a=0x0F0F0000, b=0x0000F0F0 -> out_valid 1 cycle after accept, result=0x0F0FF0F0, alu_control=011, zero=0.
REQ-033 ALUop=10, a=5, b=5 -> result=0, zero=1, ovf=0; then a=0x80000000, b=1 SUB -> result=0x7FFFFFFF, ovf=1.
REQ-034 ALUop=00, func=4, a=0xFFFFFFFF, b=1 -> result=1 (signed -1<1); a=1, b=0xFFFFFFFF -> result=0.
REQ-035 ALUop=00, func=5, a=0x00012345, b=0x00000100 -> out_valid exactly 33 cycles after accept, result=0x01234500; in_valid pulses during MUL ignored.
REQ-036 Backpressure: out_ready=0 for 10 cycles in HOLD -> result/out_valid stable, in_ready=0; out_ready=1 -> IDLE next cycle, in_ready=1.
REQ-037 rst asserted at MUL step 10 -> next cycle IDLE, out_valid=0, result=0, zero=1; fresh ADD 2+3 then yields 5.

Source files
------------

// File: rtl/alu_exec_seq.sv
// rtl/alu_exec_seq.sv - ALU execute stage with decode, valid/ready handshake and shift-add multiplier
module alu_exec_seq #(
    parameter int WIDTH  = 32,
    parameter int FUNC_W = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [1:0]        sig_ALUop,
    input  logic [FUNC_W-1:0] func,
    input  logic [WIDTH-1:0]  a,
    input  logic [WIDTH-1:0]  b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  result,
    output logic              zero,
    output logic              ovf,
    output logic [2:0]        alu_control
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_HOLD} state_t;

    state_t             state_q, state_d;
    logic [2:0]         dec_op;
    logic [WIDTH-1:0]   sum, diff, alu_res, acc_step;
    logic               alu_ovf;
    logic [WIDTH-1:0]   result_q, acc_q, mcand_q, mplier_q;
    logic               zero_q, ovf_q;
    logic [2:0]         alu_control_q;
    logic [CW-1:0]      cnt_q;

    // Whole-field compares so any func value outside 0..5 (including high bits) falls back to ADD
    always_comb begin
        dec_op = OP_ADD;
        case (sig_ALUop)
            2'b11: dec_op = OP_ADD;
            2'b10: dec_op = OP_SUB;
            2'b01: dec_op = OP_AND;
            default: begin
                case (func)
                    FUNC_W'(0): dec_op = OP_OR;
                    FUNC_W'(1): dec_op = OP_ADD;
                    FUNC_W'(2): dec_op = OP_SUB;
                    FUNC_W'(3): dec_op = OP_AND;
                    FUNC_W'(4): dec_op = OP_SLT;
                    FUNC_W'(5): dec_op = OP_MUL;
                    default:    dec_op = OP_ADD;
                endcase
            end
        endcase
    end

    assign sum  = a + b;
    assign diff = a - b;

    always_comb begin
        alu_res = sum;
        alu_ovf = 1'b0;
        case (dec_op)
            OP_ADD: begin
                alu_res = sum;
                alu_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = diff;
                alu_ovf = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_res = sum;
        endcase
    end

    assign acc_step = acc_q + (mplier_q[0] ? mcand_q : '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (in_valid) state_d = (dec_op == OP_MUL) ? S_MUL : S_HOLD;
            S_MUL:   if (cnt_q == CW'(1)) state_d = S_HOLD;
            S_HOLD:  if (out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            result_q      <= '0;
            zero_q        <= 1'b1;
            ovf_q         <= 1'b0;
            alu_control_q <= OP_ADD;
            cnt_q         <= '0;
            acc_q         <= '0;
            mcand_q       <= '0;
            mplier_q      <= '0;
        end else begin
            state_q <= state_d;
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        alu_control_q <= dec_op;
                        if (dec_op == OP_MUL) begin
                            cnt_q    <= CW'(WIDTH);
                            acc_q    <= '0;
                            mcand_q  <= a;
                            mplier_q <= b;
                        end else begin
                            result_q <= alu_res;
                            zero_q   <= (alu_res == '0);
                            ovf_q    <= alu_ovf;
                        end
                    end
                end
                S_MUL: begin
                    acc_q    <= acc_step;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CW'(1);
                    // Last step writes the result directly so out_valid rises WIDTH+1 cycles after accept
                    if (cnt_q == CW'(1)) begin
                        result_q <= acc_step;
                        zero_q   <= (acc_step == '0);
                        ovf_q    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state_q == S_IDLE);
    assign out_valid   = (state_q == S_HOLD);
    assign result      = result_q;
    assign zero        = zero_q;
    assign ovf         = ovf_q;
    assign alu_control = alu_control_q;
endmodule

// File: tb/tb_alu_exec_seq.sv
// tb/tb_alu_exec_seq.sv - directed self-checking bench for alu_exec_seq
module tb_alu_exec_seq;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  sig_ALUop = 2'b00;
    logic [3:0]  func = 4'd0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] result;
    logic        zero;
    logic        ovf;
    logic [2:0]  alu_control;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_exec_seq #(.WIDTH(32), .FUNC_W(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .sig_ALUop(sig_ALUop), .func(func), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .ovf(ovf), .alu_control(alu_control)
    );

    // Presents one request for a single edge, then counts cycles until out_valid
    task automatic issue(input logic [1:0] op, input logic [3:0] f,
                         input logic [31:0] x, input logic [31:0] y, output int lat);
        in_valid = 1'b1; sig_ALUop = op; func = f; a = x; b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1 ||
            ovf !== 1'b0 || alu_control !== 3'b000) begin
            errors++;
            $display("FAIL reset: rdy=%b vld=%b res=%h z=%b ovf=%b ctl=%b, want 1 0 0 1 0 000",
                     in_ready, out_valid, result, zero, ovf, alu_control);
        end
    endtask

    task automatic test_or();
        int lat;
        issue(2'b00, 4'd0, 32'h0F0F0000, 32'h0000F0F0, lat);
        checks++;
        if (lat !== 1 || result !== 32'h0F0FF0F0 || alu_control !== 3'b011 || zero !== 1'b0) begin
            errors++;
            $display("FAIL or: lat=%0d res=%h ctl=%b z=%b, want 1 0f0ff0f0 011 0", lat, result, alu_control, zero);
        end
        release_result();
    endtask

    task automatic test_sub();
        int lat;
        issue(2'b10, 4'd0, 32'd5, 32'd5, lat);
        checks++;
        if (result !== 32'd0 || zero !== 1'b1 || ovf !== 1'b0 || alu_control !== 3'b001) begin
            errors++;
            $display("FAIL sub_eq: res=%h z=%b ovf=%b ctl=%b, want 0 1 0 001", result, zero, ovf, alu_control);
        end
        release_result();
        issue(2'b10, 4'd0, 32'h80000000, 32'd1, lat);
        checks++;
        if (result !== 32'h7FFFFFFF || ovf !== 1'b1 || zero !== 1'b0) begin
            errors++;
            $display("FAIL sub_ovf: res=%h ovf=%b z=%b, want 7fffffff 1 0", result, ovf, zero);
        end
        release_result();
    endtask

    task automatic test_slt();
        int lat;
        issue(2'b00, 4'd4, 32'hFFFFFFFF, 32'd1, lat);
        checks++;
        if (result !== 32'd1 || alu_control !== 3'b100 || zero !== 1'b0) begin
            errors++;
            $display("FAIL slt_lt: res=%h ctl=%b z=%b, want 1 100 0", result, alu_control, zero);
        end
        release_result();
        issue(2'b00, 4'd4, 32'd1, 32'hFFFFFFFF, lat);
        checks++;
        if (result !== 32'd0 || zero !== 1'b1) begin
            errors++;
            $display("FAIL slt_ge: res=%h z=%b, want 0 1", result, zero);
        end
        release_result();
    endtask

    task automatic test_decode();
        int lat;
        issue(2'b11, 4'd5, 32'h7FFFFFFF, 32'd1, lat);
        checks++;
        if (result !== 32'h80000000 || ovf !== 1'b1 || alu_control !== 3'b000) begin
            errors++;
            $display("FAIL add_ovf: res=%h ovf=%b ctl=%b, want 80000000 1 000", result, ovf, alu_control);
        end
        release_result();
        issue(2'b11, 4'd0, 32'h80000000, 32'h80000000, lat);
        checks++;
        if (result !== 32'd0 || ovf !== 1'b1 || zero !== 1'b1) begin
            errors++;
            $display("FAIL add_negovf: res=%h ovf=%b z=%b, want 0 1 1", result, ovf, zero);
        end
        release_result();
        issue(2'b01, 4'd0, 32'hF0F0F0F0, 32'hFF00FF00, lat);
        checks++;
        if (result !== 32'hF000F000 || alu_control !== 3'b010 || ovf !== 1'b0) begin
            errors++;
            $display("FAIL and_op: res=%h ctl=%b ovf=%b, want f000f000 010 0", result, alu_control, ovf);
        end
        release_result();
        issue(2'b00, 4'd2, 32'd10, 32'd3, lat);
        checks++;
        if (result !== 32'd7 || alu_control !== 3'b001) begin
            errors++;
            $display("FAIL func_sub: res=%h ctl=%b, want 7 001", result, alu_control);
        end
        release_result();
        issue(2'b00, 4'd3, 32'h0000FFFF, 32'h00FF00FF, lat);
        checks++;
        if (result !== 32'h000000FF || alu_control !== 3'b010) begin
            errors++;
            $display("FAIL func_and: res=%h ctl=%b, want ff 010", result, alu_control);
        end
        release_result();
        issue(2'b00, 4'd9, 32'd3, 32'd4, lat);
        checks++;
        if (result !== 32'd7 || alu_control !== 3'b000) begin
            errors++;
            $display("FAIL func_default: res=%h ctl=%b, want 7 000", result, alu_control);
        end
        release_result();
    endtask

    task automatic test_mul();
        int lat;
        in_valid = 1'b1; sig_ALUop = 2'b00; func = 4'd5; a = 32'h00012345; b = 32'h00000100;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        checks++;
        if (alu_control !== 3'b101 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL mul_accept: ctl=%b rdy=%b, want 101 0", alu_control, in_ready);
        end
        // Foreign requests and operand changes while busy must not disturb the multiply
        while (!out_valid && lat < 100) begin
            in_valid = lat[0]; sig_ALUop = 2'b11; a = 32'hDEADBEEF; b = 32'h12345678;
            @(posedge clk); #1;
            lat++;
        end
        in_valid = 1'b0;
        checks++;
        if (lat !== 33 || result !== 32'h01234500 || ovf !== 1'b0 || zero !== 1'b0 || alu_control !== 3'b101) begin
            errors++;
            $display("FAIL mul: lat=%0d res=%h ovf=%b z=%b ctl=%b, want 33 01234500 0 0 101",
                     lat, result, ovf, zero, alu_control);
        end
        release_result();
    endtask

    task automatic test_back_to_back();
        int lat;
        int bad = 0;
        issue(2'b11, 4'd0, 32'd2, 32'd3, lat);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1; sig_ALUop = 2'b10; a = 32'd99;
            if (out_valid !== 1'b1 || result !== 32'd5 || in_ready !== 1'b0 || alu_control !== 3'b000) bad++;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL backpressure: %0d unstable cycles, want 0", bad);
        end
        release_result();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd5) begin
            errors++;
            $display("FAIL release: rdy=%b vld=%b res=%h, want 1 0 5", in_ready, out_valid, result);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_out_ready: rdy=%b vld=%b, want 1 0", in_ready, out_valid);
        end
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        in_valid = 1'b1; sig_ALUop = 2'b00; func = 4'd5; a = 32'd7; b = 32'd9;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 32'd0 || zero !== 1'b1 || alu_control !== 3'b000) begin
            errors++;
            $display("FAIL mul_abort: rdy=%b vld=%b res=%h z=%b ctl=%b, want 1 0 0 1 000",
                     in_ready, out_valid, result, zero, alu_control);
        end
        issue(2'b11, 4'd0, 32'd2, 32'd3, lat);
        checks++;
        if (lat !== 1 || result !== 32'd5 || zero !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_add: lat=%0d res=%h z=%b, want 1 5 0", lat, result, zero);
        end
        release_result();
    endtask

    initial begin
        test_reset();
        test_or();
        test_sub();
        test_slt();
        test_decode();
        test_mul();
        test_back_to_back();
        test_reset_mid_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
